// File: rtl/simple_bus_responder.sv
// simple_bus_responder
//
// Single-master bus responder with a 256 x 8 storage array. A master raises req
// and is granted the bus. While granted, a start strobe launches one access on the
// address, mode and write data captured with it. The access completes after a
// fixed wait period and is acknowledged by a one-cycle rdy pulse. A grant that sits
// idle for TIMEOUT cycles is withdrawn.
//
// Parameters
//   WAIT_CYCLES  extra wait cycles before each access completes (0..15)
//   TIMEOUT      granted cycles without start before the grant is withdrawn (1..255)
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   1  master bus request
//   start  in   1  transfer start strobe, honoured only while granted
//   addr   in   8  transfer address
//   mode   in   2  00 read, 01 write, 10 read-increment, 11 illegal
//   wdata  in   8  write data
//   gnt    out  1  grant to master (registered)
//   rdy    out  1  one-cycle transfer-complete strobe (registered)
//   rdata  out  8  read data, held between responses (registered)
//   err    out  1  illegal-mode flag, valid only with rdy (registered)

module simple_bus_responder #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [1:0] mode,
    input  logic [7:0] wdata,
    output logic       gnt,
    output logic       rdy,
    output logic [7:0] rdata,
    output logic       err
);

    localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);
    localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGranted,
        StBusy,
        StResp
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] tmo_q, tmo_d;

    // Transfer parameters captured with start
    logic [7:0] addr_q, wdata_q;
    logic [1:0] mode_q;

    logic       latch;
    logic       access;

    logic       gnt_q, rdy_q, err_q, err_d;
    logic [7:0] rdata_q, rdata_d;

    logic [7:0] mem [256];
    logic       mem_we;
    logic [7:0] mem_wdata;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        latch   = 1'b0;
        access  = 1'b0;
        case (state_q)
            StIdle: begin
                tmo_d = 8'd0;
                if (req) begin
                    state_d = StGranted;
                end
            end
            StGranted: begin
                // start wins over a simultaneous req drop or timeout
                if (start) begin
                    latch   = 1'b1;
                    wait_d  = 4'd0;
                    tmo_d   = 8'd0;
                    state_d = StBusy;
                end else if (!req || (tmo_q == TmoLast)) begin
                    tmo_d   = 8'd0;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StBusy: begin
                if (wait_q == WaitLast) begin
                    access  = 1'b1;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StResp: begin
                tmo_d   = 8'd0;
                state_d = req ? StGranted : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Access decode, evaluated only on the BUSY -> RESP transition
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        if (access) begin
            case (mode_q)
                2'b00: begin
                    rdata_d = mem[addr_q];
                end
                2'b01: begin
                    mem_we = 1'b1;
                end
                2'b10: begin
                    rdata_d   = mem[addr_q];
                    mem_we    = 1'b1;
                    mem_wdata = mem[addr_q] + 8'd1;
                end
                default: begin
                    err_d   = 1'b1;
                    rdata_d = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            tmo_q   <= 8'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            mode_q  <= 2'b00;
            gnt_q   <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            if (latch) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                mode_q  <= mode;
            end
            // Grant covers GRANTED, BUSY and RESP so back-to-back transfers keep it high
            gnt_q   <= (state_d != StIdle);
            rdy_q   <= access;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately not reset; mem_we derives from state_q, which reset
    // forces to IDLE, so an interrupted access never writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= mem_wdata;
        end
    end

    assign gnt   = gnt_q;
    assign rdy   = rdy_q;
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_simple_bus_responder.sv
module tb_simple_bus_responder;

    localparam int W   = 1;
    localparam int TMO = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req   = 1'b0;
    logic       start = 1'b0;
    logic [7:0] addr  = 8'h00;
    logic [1:0] mode  = 2'b00;
    logic [7:0] wdata = 8'h00;
    logic       gnt, rdy, err;
    logic [7:0] rdata;

    int total = 0;
    int bad   = 0;

    // Reference model: memory contents and the last value presented on rdata
    logic [7:0] mem_model [256];
    logic [7:0] last_rdata = 8'h00;

    bit mon_en    = 1'b0;
    int gnt_drops = 0;

    simple_bus_responder #(
        .WAIT_CYCLES(W),
        .TIMEOUT    (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .start(start),
        .addr (addr),
        .mode (mode),
        .wdata(wdata),
        .gnt  (gnt),
        .rdy  (rdy),
        .rdata(rdata),
        .err  (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mon_en && !gnt) gnt_drops++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_op(input logic [7:0] a, input logic [1:0] m, input logic [7:0] d,
                            output logic [7:0] er, output logic ee);
        case (m)
            2'b00: last_rdata = mem_model[a];
            2'b01: mem_model[a] = d;
            2'b10: begin
                last_rdata   = mem_model[a];
                mem_model[a] = mem_model[a] + 8'd1;
            end
            default: last_rdata = 8'h00;
        endcase
        er = last_rdata;
        ee = (m == 2'b11);
    endtask

    // Runs one transfer; lat = cycles from the start edge to the rdy cycle, -1 if none.
    // Noise is driven on start/addr/mode/wdata while busy, and start is raised during RESP.
    task automatic do_xfer(input logic [7:0] a, input logic [1:0] m, input logic [7:0] d,
                           input bit keep_req, output logic [7:0] r, output logic e,
                           output int lat, output logic rdy_after, output logic gnt_after);
        int n;
        lat = -1; r = 8'h00; e = 1'b0; rdy_after = 1'bx; gnt_after = 1'bx;
        req = 1'b1;
        n = 0;
        while (!gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!gnt) begin
            req = 1'b0;
            return;
        end
        addr = a; mode = m; wdata = d; start = 1'b1;
        @(negedge clk);
        n = 0;
        while (n < 40) begin
            start = 1'($urandom_range(0, 1));
            addr  = 8'($urandom);
            mode  = 2'($urandom);
            wdata = 8'($urandom);
            @(negedge clk);
            n++;
            if (rdy) break;
        end
        if (!rdy) begin
            start = 1'b0;
            req   = 1'b0;
            return;
        end
        lat = n;
        r   = rdata;
        e   = err;
        req   = keep_req;
        start = 1'b1;
        @(negedge clk);
        rdy_after = rdy;
        gnt_after = gnt;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (gnt !== 1'b0) begin bad++; $display("FAIL reset.gnt got=%b exp=0", gnt); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset.rdy got=%b exp=0", rdy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset.err got=%b exp=0", err); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset.rdata got=%h exp=00", rdata); end
        rst_n = 1'b1;
        last_rdata = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        logic [7:0] r, er; logic e, ee, ra, ga; int lat;
        model_op(8'h10, 2'b01, 8'hA5, er, ee);
        do_xfer(8'h10, 2'b01, 8'hA5, 1'b0, r, e, lat, ra, ga);
        total++; if (lat != W + 1) begin bad++; $display("FAIL wr.latency got=%0d exp=%0d", lat, W + 1); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL wr.rdy_width got=%b exp=0", ra); end
        total++; if (e !== ee) begin bad++; $display("FAIL wr.err got=%b exp=%b", e, ee); end
        total++; if (r !== er) begin bad++; $display("FAIL wr.rdata_hold got=%h exp=%h", r, er); end
        model_op(8'h10, 2'b00, 8'h00, er, ee);
        do_xfer(8'h10, 2'b00, 8'h00, 1'b0, r, e, lat, ra, ga);
        total++; if (lat != W + 1) begin bad++; $display("FAIL rd.latency got=%0d exp=%0d", lat, W + 1); end
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL rd.rdy_width got=%b exp=0", ra); end
        total++; if (r !== 8'hA5) begin bad++; $display("FAIL rd.rdata got=%h exp=a5", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL rd.err got=%b exp=0", e); end
    endtask

    task automatic test_read_increment;
        logic [7:0] r, er; logic e, ee, ra, ga; int lat;
        model_op(8'h20, 2'b01, 8'hFF, er, ee);
        do_xfer(8'h20, 2'b01, 8'hFF, 1'b0, r, e, lat, ra, ga);
        model_op(8'h20, 2'b10, 8'h00, er, ee);
        do_xfer(8'h20, 2'b10, 8'h00, 1'b0, r, e, lat, ra, ga);
        total++; if (r !== 8'hFF) begin bad++; $display("FAIL rinc.rdata got=%h exp=ff", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL rinc.err got=%b exp=0", e); end
        model_op(8'h20, 2'b00, 8'h00, er, ee);
        do_xfer(8'h20, 2'b00, 8'h00, 1'b0, r, e, lat, ra, ga);
        total++; if (r !== 8'h00) begin bad++; $display("FAIL rinc.wrap got=%h exp=00", r); end
    endtask

    task automatic test_illegal;
        logic [7:0] r, er; logic e, ee, ra, ga; int lat;
        model_op(8'h30, 2'b01, 8'h5A, er, ee);
        do_xfer(8'h30, 2'b01, 8'h5A, 1'b0, r, e, lat, ra, ga);
        model_op(8'h30, 2'b11, 8'h00, er, ee);
        do_xfer(8'h30, 2'b11, 8'h00, 1'b0, r, e, lat, ra, ga);
        total++; if (lat != W + 1) begin bad++; $display("FAIL ill.latency got=%0d exp=%0d", lat, W + 1); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL ill.err got=%b exp=1", e); end
        total++; if (r !== 8'h00) begin bad++; $display("FAIL ill.rdata got=%h exp=00", r); end
        model_op(8'h30, 2'b00, 8'h00, er, ee);
        do_xfer(8'h30, 2'b00, 8'h00, 1'b0, r, e, lat, ra, ga);
        total++; if (r !== 8'h5A) begin bad++; $display("FAIL ill.mem_kept got=%h exp=5a", r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL ill.err_clear got=%b exp=0", e); end
    endtask

    task automatic test_timeout;
        logic exp_g;
        req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            // TMO cycles granted, one cycle idle, then regranted
            exp_g = ((i % (TMO + 1)) != TMO);
            total++;
            if (gnt !== exp_g) begin bad++; $display("FAIL timeout.gnt[%0d] got=%b exp=%b", i, gnt, exp_g); end
        end
        req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_busy;
        logic [7:0] r, er; logic e, ee, ra, ga; int lat;
        model_op(8'h40, 2'b01, 8'h11, er, ee);
        do_xfer(8'h40, 2'b01, 8'h11, 1'b0, r, e, lat, ra, ga);
        // leave a nonzero rdata so the asynchronous clear is visible
        model_op(8'h30, 2'b00, 8'h00, er, ee);
        do_xfer(8'h30, 2'b00, 8'h00, 1'b0, r, e, lat, ra, ga);
        req = 1'b1;
        @(negedge clk);
        addr = 8'h40; mode = 2'b01; wdata = 8'h77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);  // now in the last busy cycle
        rst_n = 1'b0;
        #1;
        total++; if (gnt !== 1'b0) begin bad++; $display("FAIL rstbusy.gnt got=%b exp=0", gnt); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rstbusy.rdy got=%b exp=0", rdy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rstbusy.err got=%b exp=0", err); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rstbusy.rdata got=%h exp=00", rdata); end
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 8'h00;
        req = 1'b1;
        @(negedge clk);
        total++; if (gnt !== 1'b1) begin bad++; $display("FAIL rstbusy.first_req got=%b exp=1", gnt); end
        model_op(8'h40, 2'b00, 8'h00, er, ee);
        do_xfer(8'h40, 2'b00, 8'h00, 1'b0, r, e, lat, ra, ga);
        total++; if (r !== 8'h11) begin bad++; $display("FAIL rstbusy.mem got=%h exp=11", r); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] r, er; logic e, ee, ra, ga; int lat1, lat2;
        req = 1'b1;
        @(negedge clk);
        gnt_drops = 0;
        mon_en = 1'b1;
        model_op(8'h50, 2'b01, 8'hC3, er, ee);
        do_xfer(8'h50, 2'b01, 8'hC3, 1'b1, r, e, lat1, ra, ga);
        total++; if (ra !== 1'b0) begin bad++; $display("FAIL b2b.rdy1_width got=%b exp=0", ra); end
        model_op(8'h51, 2'b01, 8'h3C, er, ee);
        do_xfer(8'h51, 2'b01, 8'h3C, 1'b1, r, e, lat2, ra, ga);
        mon_en = 1'b0;
        total++; if (gnt_drops != 0) begin bad++; $display("FAIL b2b.gnt_drops got=%0d exp=0", gnt_drops); end
        total++; if (lat1 != W + 1) begin bad++; $display("FAIL b2b.lat1 got=%0d exp=%0d", lat1, W + 1); end
        total++; if (lat2 != W + 1) begin bad++; $display("FAIL b2b.lat2 got=%0d exp=%0d", lat2, W + 1); end
        model_op(8'h50, 2'b00, 8'h00, er, ee);
        do_xfer(8'h50, 2'b00, 8'h00, 1'b1, r, e, lat1, ra, ga);
        total++; if (r !== 8'hC3) begin bad++; $display("FAIL b2b.mem50 got=%h exp=c3", r); end
        model_op(8'h51, 2'b00, 8'h00, er, ee);
        do_xfer(8'h51, 2'b00, 8'h00, 1'b0, r, e, lat1, ra, ga);
        total++; if (r !== 8'h3C) begin bad++; $display("FAIL b2b.mem51 got=%h exp=3c", r); end
    endtask

    task automatic test_random;
        logic [7:0] r, er, a, d; logic [1:0] m; logic e, ee, ra, ga; int lat; bit keep;
        for (int i = 0; i < 8; i++) begin
            a = 8'h80 + 8'(i);
            d = 8'($urandom);
            model_op(a, 2'b01, d, er, ee);
            do_xfer(a, 2'b01, d, 1'b0, r, e, lat, ra, ga);
        end
        for (int i = 0; i < 40; i++) begin
            a    = 8'h80 + 8'($urandom_range(0, 7));
            m    = 2'($urandom_range(0, 3));
            d    = 8'($urandom);
            keep = 1'($urandom_range(0, 1));
            model_op(a, m, d, er, ee);
            do_xfer(a, m, d, keep, r, e, lat, ra, ga);
            total++; if (lat != W + 1) begin bad++; $display("FAIL rnd[%0d].latency got=%0d exp=%0d", i, lat, W + 1); end
            total++; if (r !== er) begin bad++; $display("FAIL rnd[%0d].rdata mode=%0d got=%h exp=%h", i, m, r, er); end
            total++; if (e !== ee) begin bad++; $display("FAIL rnd[%0d].err got=%b exp=%b", i, e, ee); end
            total++; if (ra !== 1'b0) begin bad++; $display("FAIL rnd[%0d].rdy_width got=%b exp=0", i, ra); end
            total++; if (ga !== keep) begin bad++; $display("FAIL rnd[%0d].gnt_after got=%b exp=%b", i, ga, keep); end
        end
        for (int i = 0; i < 8; i++) begin
            a = 8'h80 + 8'(i);
            model_op(a, 2'b00, 8'h00, er, ee);
            do_xfer(a, 2'b00, 8'h00, 1'b0, r, e, lat, ra, ga);
            total++; if (r !== er) begin bad++; $display("FAIL rnd.final[%h] got=%h exp=%h", a, r, er); end
        end
        req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_increment();
        test_illegal();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_bus_responder.md
SIMPLE_BUS_RESPONDER -- requirements
Module: simple_bus_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1: extra wait cycles inserted before every access completes (range 0..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 15: number of granted cycles without start before the grant is withdrawn (range 1..255).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports named in the codebase style: clk  input  1  rising-edge clock, then rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  1  master bus request.
REQ-005 start  input  1  transfer start strobe, sampled only while granted.
REQ-006 addr  input  8  transfer address.
REQ-007 mode  input  2  transfer type: 00 read, 01 write, 10 read-increment, 11 illegal.
REQ-008 wdata  input  8  write data, the master-driven half of the shared data bus.
REQ-009 gnt  output  1  grant to master.
REQ-010 rdy  output  1  one-cycle transfer-complete strobe.
REQ-011 rdata  output  8  read data, the responder-driven half of the shared data bus.
REQ-012 err  output  1  error flag, valid only with rdy.

Function
REQ-013 The block SHALL contain a 256 x 8 storage array indexed by addr.
REQ-014 The FSM SHALL have four states: IDLE, GRANTED, BUSY and RESP.
REQ-015 IDLE: gnt=0; req sampled high SHALL move the FSM to GRANTED, with gnt=1 from the next cycle.
REQ-016 GRANTED: gnt=1; start sampled high SHALL latch addr, mode and wdata, clear the wait counter and move the FSM to BUSY.
REQ-017 GRANTED: req sampled low with start low SHALL return the FSM to IDLE, with gnt=0 on the next cycle.
REQ-018 GRANTED: TIMEOUT consecutive cycles without start SHALL return the FSM to IDLE and drop gnt, even if req is still high; a new grant then follows the normal IDLE rule.
REQ-019 BUSY SHALL last exactly WAIT_CYCLES+1 cycles, with gnt held at 1; start, addr, mode and wdata changes during BUSY SHALL be ignored.
REQ-020 On leaving BUSY, the access SHALL be performed on the latched values and the FSM SHALL enter RESP.
REQ-021 Read (00): rdata SHALL be set to mem[addr]; the memory is unchanged.
REQ-022 Write (01): mem[addr] SHALL be set to wdata; rdata keeps its previous value.
REQ-023 Read-increment (10): rdata SHALL be set to the old mem[addr], and mem[addr] SHALL be set to old+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-024 Illegal (11): err SHALL be 1, the memory is unchanged, and rdata SHALL be 8'h00.
REQ-025 For legal modes, err SHALL be 0.
REQ-026 RESP: rdy=1 for exactly one cycle, with rdata and err valid in that cycle.
REQ-027 From RESP, req high SHALL lead to GRANTED with gnt held continuously (back-to-back transfers); req low SHALL lead to IDLE.
REQ-028 Latency: with start sampled at edge T, rdy SHALL be high in the cycle following edge T+WAIT_CYCLES+1.
REQ-029 start with req low while in GRANTED SHALL still be accepted (start has priority over a req drop in the same cycle).
REQ-030 start sampled in IDLE or RESP SHALL be ignored.
REQ-031 rdata SHALL hold its value between responses; it is updated only when RESP is entered.
REQ-032 gnt, rdy and err SHALL be driven from registers, with no combinational path from inputs.

Reset
REQ-033 rst_n low SHALL asynchronously force the FSM to IDLE and set gnt=0, rdy=0, err=0, rdata=8'h00, and clear the wait and timeout counters.
REQ-034 Reset SHALL NOT alter the memory contents.
REQ-035 A transfer interrupted by reset SHALL be abandoned with no memory write, even if reset occurs in the last BUSY cycle.
REQ-036 After rst_n deasserts, the first req SHALL be honoured on the first rising edge at which it is sampled high.

Verification
REQ-037 WAIT_CYCLES=1: write 8'hA5 to addr 8'h10, then read 8'h10 -> each rdy pulse is 1 cycle, occurring 2 cycles after start is sampled; read rdata=8'hA5, err=0.
REQ-038 Read-increment on addr 8'h20 holding 8'hFF -> rdata=8'hFF; a subsequent read returns 8'h00.
REQ-039 mode=11 on addr 8'h30 holding 8'h5A -> rdy=1 and err=1 with rdata=8'h00; a later read returns 8'h5A.
REQ-040 req held with no start, TIMEOUT=4 -> gnt high for 4 cycles, then low for one cycle, then regranted.
REQ-041 rst_n pulsed low in the BUSY state of a write of 8'h77 to addr 8'h40 holding 8'h11 -> all outputs 0 immediately; a read after reset returns 8'h11.
REQ-042 Two back-to-back writes with req held high -> gnt never drops, two separate rdy pulses, both locations updated.
